pmem_responder: RTL and testbench
=================================

Name: pmem_responder

Overview:
- Cycle-accurate physical-memory responder: the memory end of the 256-bit line protocol driven by the eviction write buffer (pmem_read/pmem_write/pmem_address/pmem_wdata in; pmem_resp/pmem_rdata out).
- Holds a line-granular backing store.
- Services one read or write per transaction after a fixed, programmable latency.
- Used as the memory model under the cache hierarchy, and as a standalone responder for cache/EWB unit benches.

Parameters:
- LATENCY, 10, cycles spent in BUSY before the response cycle (legal range 1..255).
- INDEX_BITS, 8, log2 of the number of 256-bit lines stored (default 256 lines = 8 KiB).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- pmem_read  input  1  read request; requester holds it high until pmem_resp.
- pmem_write  input  1  write request; requester holds it high until pmem_resp.
- pmem_address  input  32  byte address; bits [4:0] ignored (line aligned).
- pmem_wdata  input  256  write line; sampled in the response cycle.
- pmem_resp  output  1  one-cycle completion pulse.
- pmem_rdata  output  256  read line; valid while pmem_resp is high.

Behaviour:
- FSM states: IDLE, BUSY, RESP.
- Reset (rst=1 at an edge, from any state):
  - State goes to IDLE; latency counter cleared; pmem_resp=0; pmem_rdata=0.
  - The backing store is not modified by reset. It powers up all zero.
  - Reset mid-BUSY or in RESP aborts the transaction; no write is committed.
- IDLE:
  - If pmem_read or pmem_write is high, latch the op type and line index = pmem_address[5+INDEX_BITS-1:5], load the counter with LATENCY-1, and go to BUSY.
  - Address bits above the index alias (wrap modulo the store size).
- Simultaneous pmem_read and pmem_write in IDLE is a protocol violation. Write wins; the transaction proceeds as a write.
- BUSY:
  - The counter decrements each cycle. When it reaches 0, go to RESP.
  - If both pmem_read and pmem_write are low in any BUSY cycle, the requester abandoned the request: return to IDLE, no response, no commit.
  - Address and op changes during BUSY are ignored; the latched values are used.
- RESP (exactly one cycle):
  - pmem_resp=1.
  - Read: pmem_rdata = store[latched index].
  - Write: store[latched index] <= pmem_wdata at the closing edge; pmem_rdata is unchanged.
  - Next state is always IDLE.
- Timing: request first high in cycle 0 → pmem_resp high in cycle LATENCY+1 (default: cycle 11).
- Back-to-back: a request seen in the IDLE cycle right after RESP starts a new transaction; minimum spacing is LATENCY+2 cycles per transaction.
- Outside RESP: pmem_resp=0, and pmem_rdata holds its last driven value.
- Read-after-write to the same line returns the newly written data. The write commits before any later transaction is accepted.

Optional Feature:
- Macro: PMEM_RESPONDER_STATS_EN.
- When defined, adds three outputs:
  - stat_reads  output  32  count of completed read transactions.
  - stat_writes  output  32  count of completed write transactions.
  - stat_aborts  output  32  count of transactions abandoned in BUSY.
- Each counter increments at the closing edge of the qualifying cycle and wraps from 0xFFFFFFFF to 0. All three clear on rst.
- When not defined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
1. LATENCY=4: write 0xA5 repeated into addr 0x00000040, then read 0x00000040 → write resp pulse in cycle 5; read resp in cycle 5 of its transaction with pmem_rdata = 0xA5 repeated; pmem_resp high exactly one cycle each time.
2. Read 0x0000005F, then read 0x00002040 (INDEX_BITS=8) → both return the line at index 2 (low-bit masking and high-bit aliasing); an unwritten line returns 0.
3. Drop pmem_read in cycle 2 of a read with LATENCY=4 → no pmem_resp; FSM back in IDLE; a following read completes normally at LATENCY+1; stat_aborts=1 with PMEM_RESPONDER_STATS_EN.
4. Assert rst in cycle 3 of a write to 0x80 → pmem_resp never asserts; a later read of 0x80 returns the old contents (0); pmem_rdata=0 after reset.
5. pmem_read and pmem_write both high with wdata 0x1 pattern at 0x100 → treated as a write; a subsequent read of 0x100 returns the 0x1 pattern.
6. LATENCY=1: ten back-to-back reads with the request held continuously → one resp every 3 cycles; stat_reads=10.

Source files
------------

// File: rtl/pmem_responder_if.sv
// Purpose: 256-bit line-protocol bundle between a requester (cache/EWB) and pmem_responder.
// Latency: none, wires only.
// Backpressure: requester holds read/write high until a one-cycle pmem_resp pulse.
//
// Signals:
//   pmem_read/pmem_write - request strobes (requester -> memory)
//   pmem_address         - byte address; line aligned, bits [4:0] ignored
//   pmem_wdata           - write line, sampled in the response cycle
//   pmem_resp            - one-cycle completion pulse (memory -> requester)
//   pmem_rdata           - read line, valid while pmem_resp is high
interface pmem_responder_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/pmem_responder.sv
// Purpose: line-granular physical-memory model answering one read or write per transaction.
// Latency: request first high in cycle 0 -> pmem_resp in cycle LATENCY+1; spacing LATENCY+2.
// Backpressure: requester holds its strobe until pmem_resp; dropping it in BUSY abandons the request.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   pmem     - slave side of pmem_responder_if (read/write/address/wdata in, resp/rdata out)
//   stat_reads/stat_writes/stat_aborts - 32-bit wrapping counters, present only when
//   PMEM_RESPONDER_STATS_EN is defined.
// Parameters: LATENCY (1..255) BUSY cycles before the response; INDEX_BITS = log2(lines).
module pmem_responder #(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    pmem_responder_if.slave  pmem
`ifdef PMEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]      stat_reads,
    output logic [31:0]      stat_writes,
    output logic [31:0]      stat_aborts
`endif
);

    localparam int unsigned DEPTH = 1 << INDEX_BITS;
    localparam logic [7:0]  LOAD  = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic [7:0]              r_count;
    logic                    r_is_write;
    logic [INDEX_BITS-1:0]   r_index;
    logic                    r_resp;
    logic [255:0]            r_rdata;

    // Backing store. Never touched by reset; relies on power-up zero contents.
    logic [255:0]            r_mem [DEPTH];

    logic                    w_req;
    logic [INDEX_BITS-1:0]   w_index;
    logic                    w_unused_addr;

    assign w_req   = pmem.pmem_read | pmem.pmem_write;
    // Upper address bits simply fall off, so addresses alias modulo the store size.
    assign w_index = pmem.pmem_address[5 +: INDEX_BITS];
    assign w_unused_addr = ^{pmem.pmem_address[4:0], pmem.pmem_address[31:5+INDEX_BITS]};

    assign pmem.pmem_resp  = r_resp;
    assign pmem.pmem_rdata = r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_is_write <= 1'b0;
            r_index    <= '0;
            r_resp     <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        // Both strobes high is illegal; treating it as a write keeps data safe.
                        r_is_write <= pmem.pmem_write;
                        r_index    <= w_index;
                        r_count    <= LOAD;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_req) begin
                        r_state <= IDLE;
                    end else if (r_count == 8'd0) begin
                        // Response data is registered on entry to RESP so it is valid with the pulse.
                        r_state <= RESP;
                        r_resp  <= 1'b1;
                        if (!r_is_write) begin
                            r_rdata <= r_mem[r_index];
                        end
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Write commits at the closing edge of RESP; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (!rst && r_state == RESP && r_is_write) begin
            r_mem[r_index] <= pmem.pmem_wdata;
        end
    end

`ifdef PMEM_RESPONDER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_aborts <= '0;
        end else begin
            if (r_state == RESP && !r_is_write) begin
                stat_reads <= stat_reads + 32'd1;
            end
            if (r_state == RESP && r_is_write) begin
                stat_writes <= stat_writes + 32'd1;
            end
            if (r_state == BUSY && !w_req) begin
                stat_aborts <= stat_aborts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Purpose: self-checking bench for pmem_responder (LATENCY=4 main instance, LATENCY=1 for streaming).
// Latency: checks response cycle = LATENCY+1 and one-cycle pulse width.
// Backpressure: requester holds strobes until pmem_resp, then drops them for one idle cycle.
module tb_pmem_responder;

    localparam int LAT4 = 4;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pmem_responder_if pif4();
    pmem_responder_if pif1();

`ifdef PMEM_RESPONDER_STATS_EN
    logic [31:0] st4_reads, st4_writes, st4_aborts;
    logic [31:0] st1_reads, st1_writes, st1_aborts;
`endif

    pmem_responder #(.LATENCY(LAT4), .INDEX_BITS(8)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .pmem (pif4)
`ifdef PMEM_RESPONDER_STATS_EN
        ,
        .stat_reads  (st4_reads),
        .stat_writes (st4_writes),
        .stat_aborts (st4_aborts)
`endif
    );

    pmem_responder #(.LATENCY(LAT1), .INDEX_BITS(8)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .pmem (pif1)
`ifdef PMEM_RESPONDER_STATS_EN
        ,
        .stat_reads  (st1_reads),
        .stat_writes (st1_writes),
        .stat_aborts (st1_aborts)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain line array plus the "rdata holds unless a read completes" rule.
    logic [255:0] model_mem [256];
    logic [255:0] last_rdata;
    int           m_reads, m_writes, m_aborts;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_apply(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [255:0] wd, output logic [255:0] exp);
        int idx;
        idx = int'(a[12:5]);
        if (wr) begin
            model_mem[idx] = wd;
            m_writes++;
        end else if (rd) begin
            last_rdata = model_mem[idx];
            m_reads++;
        end
        exp = last_rdata;
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge with the DUT idle.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [255:0] wd, output int cyc, output logic [255:0] rdat);
        pif4.pmem_read    = rd;
        pif4.pmem_write   = wr;
        pif4.pmem_address = a;
        pif4.pmem_wdata   = wd;
        cyc  = -1;
        rdat = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (pif4.pmem_resp) begin
                cyc  = c;
                rdat = pif4.pmem_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        if (cyc < 0) begin
            errors++;
            $display("FAIL txn_timeout no pmem_resp within 300 cycles");
        end
        @(posedge clk); #1;
        pif4.pmem_read  = 1'b0;
        pif4.pmem_write = 1'b0;
        @(negedge clk);
        check_int("pulse_width", 32'(pif4.pmem_resp), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] pat_a5, pat_01, wd, exp, rdat;
        logic [31:0]  addr;
        logic         rd, wr;
        int           cyc, seen, nresp, sel;
        logic         spacing_ok;

        pat_a5 = {32{8'hA5}};
        pat_01 = {32{8'h01}};

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0040, pat_a5, 256'd0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, 256'd0, pat_a5};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_005F, 256'd0, pat_a5};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_2040, 256'd0, pat_a5};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0060, 256'd0, 256'd0};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0100, pat_01, 256'd0};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0100, 256'd0, pat_01};

        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        last_rdata = '0;
        m_reads = 0; m_writes = 0; m_aborts = 0;

        pif4.pmem_read = 1'b0; pif4.pmem_write = 1'b0;
        pif4.pmem_address = '0; pif4.pmem_wdata = '0;
        pif1.pmem_read = 1'b0; pif1.pmem_write = 1'b0;
        pif1.pmem_address = '0; pif1.pmem_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("rst_resp4", 32'(pif4.pmem_resp), 32'd0);
        check("rst_rdata4", pif4.pmem_rdata, 256'd0);
        check_int("rst_resp1", 32'(pif1.pmem_resp), 32'd0);
        check("rst_rdata1", pif1.pmem_rdata, 256'd0);
`ifdef PMEM_RESPONDER_STATS_EN
        check_int("rst_stat_reads", st4_reads, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed table: write/read, masking, aliasing, unwritten line, dual strobe
        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, cyc, rdat);
            model_apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, exp);
            check_int($sformatf("vec%0d_latency", i), 32'(cyc), 32'(LAT4 + 1));
            check($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rdata);
        end

        // Abandoned read: strobe dropped in cycle 2
        pif4.pmem_read = 1'b1; pif4.pmem_address = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pif4.pmem_read = 1'b0;
        m_aborts++;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (pif4.pmem_resp) seen = 1;
            @(posedge clk); #1;
        end
        check_int("abort_no_resp", 32'(seen), 32'd0);
        check("abort_rdata_held", pif4.pmem_rdata, last_rdata);
`ifdef PMEM_RESPONDER_STATS_EN
        check_int("abort_stat", st4_aborts, 32'(m_aborts));
`endif
        do_txn(1'b1, 1'b0, 32'h40, 256'd0, cyc, rdat);
        model_apply(1'b1, 1'b0, 32'h40, 256'd0, exp);
        check_int("after_abort_latency", 32'(cyc), 32'(LAT4 + 1));
        check("after_abort_rdata", rdat, pat_a5);

        // Reset in cycle 3 of a write to 0x80: no response, no commit
        pif4.pmem_write = 1'b1; pif4.pmem_address = 32'h80; pif4.pmem_wdata = {8{32'hDEAD_BEEF}};
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (pif4.pmem_resp) seen = 1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        pif4.pmem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (pif4.pmem_resp) seen = 1;
            @(posedge clk); #1;
        end
        check_int("rst_mid_no_resp", 32'(seen), 32'd0);
        check("rst_mid_rdata", pif4.pmem_rdata, 256'd0);
        last_rdata = '0;
        m_reads = 0; m_writes = 0; m_aborts = 0;
        do_txn(1'b1, 1'b0, 32'h80, 256'd0, cyc, rdat);
        model_apply(1'b1, 1'b0, 32'h80, 256'd0, exp);
        check_int("rst_read_latency", 32'(cyc), 32'(LAT4 + 1));
        check("rst_read_old", rdat, 256'd0);

        // Randomized traffic over a few aliased lines against the model
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            rd = (sel < 5) || (sel == 9);
            wr = (sel >= 5);
            addr = $urandom;
            addr[12:5] = 8'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom;
            check($sformatf("rnd%0d_hold", i), pif4.pmem_rdata, last_rdata);
            do_txn(rd, wr, addr, wd, cyc, rdat);
            model_apply(rd, wr, addr, wd, exp);
            check_int($sformatf("rnd%0d_latency", i), 32'(cyc), 32'(LAT4 + 1));
            check($sformatf("rnd%0d_rdata", i), rdat, exp);
        end

`ifdef PMEM_RESPONDER_STATS_EN
        check_int("stat_reads4", st4_reads, 32'(m_reads));
        check_int("stat_writes4", st4_writes, 32'(m_writes));
        check_int("stat_aborts4", st4_aborts, 32'(m_aborts));
`endif

        // LATENCY=1 streaming: read held continuously -> responses in cycles 2,5,...,29
        pif1.pmem_read = 1'b1; pif1.pmem_address = 32'h40;
        nresp = 0;
        spacing_ok = 1'b1;
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            if (pif1.pmem_resp) begin
                if (c != 2 + 3 * nresp) spacing_ok = 1'b0;
                nresp++;
            end
            @(posedge clk); #1;
            if (c == 29) pif1.pmem_read = 1'b0;
        end
        check_int("b2b_count", 32'(nresp), 32'd10);
        check_int("b2b_spacing", 32'(spacing_ok), 32'd1);
        check("b2b_rdata", pif1.pmem_rdata, 256'd0);
`ifdef PMEM_RESPONDER_STATS_EN
        check_int("b2b_stat_reads", st1_reads, 32'd10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
